// File: rtl/controller_registers.sv
// Per-frame controller fetch scheduler plus CPU-visible button/edge/frame registers.
// Optional CONTROLLER_REGISTERS_SOCD_FILTER_EN cancels opposing D-pad directions before capture.

module controller_registers_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_i,
  input  logic       clr_prs_i,
  input  logic       clr_rel_i,
  input  logic [7:0] btn_i,
  output logic [7:0] cur_o,
  output logic [7:0] prs_o,
  output logic [7:0] rel_o
);
  logic [7:0] cur_q, cur_d;
  logic [7:0] prs_q, prs_d;
  logic [7:0] rel_q, rel_d;

  // A read clear and a capture on the same edge keep only the fresh edges.
  always_comb begin
    cur_d = cur_q;
    prs_d = clr_prs_i ? 8'h00 : prs_q;
    rel_d = clr_rel_i ? 8'h00 : rel_q;
    if (sample_i) begin
      prs_d = prs_d | (btn_i & ~cur_q);
      rel_d = rel_d | (~btn_i & cur_q);
      cur_d = btn_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= 8'h00;
      prs_q <= 8'h00;
      rel_q <= 8'h00;
    end else begin
      cur_q <= cur_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
    end
  end

  assign cur_o = cur_q;
  assign prs_o = prs_q;
  assign rel_o = rel_q;
endmodule

module controller_registers #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vblank_start,
  output logic                         start_fetch,
  input  logic [8*NUM_CONTROLLERS-1:0] controller_buttons_in_LIST,
  input  logic [3:0]                   cpu_address,
  input  logic                         cpu_read_en,
  output logic [7:0]                   cpu_data_out,
  output logic                         sample_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, SETTLE, SAMPLE} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] frame_q;
  logic [7:0] dout_q;
  logic       sv_q;
  logic       do_sample;

  logic [NUM_CONTROLLERS-1:0][7:0] btn_f, cur, prs, rel;
  logic [NUM_CONTROLLERS-1:0]      clr_prs, clr_rel;
  logic [1:0]                      rd_idx, rd_sel;
  logic [7:0]                      rd_data;

  assign rd_idx = cpu_address[3:2];
  assign rd_sel = cpu_address[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (vblank_start) state_d = FETCH;
      FETCH: begin
        cnt_d   = 8'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE:  if (cnt_q == 8'h00) state_d = SAMPLE;
               else                cnt_d   = cnt_q - 8'h01;
      SAMPLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_fetch = (state_q == FETCH);
    do_sample   = (state_q == SAMPLE);
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CONTROLLERS; k++) begin : g_lane
      logic [7:0] raw;
      logic       hit;
      assign raw = controller_buttons_in_LIST[8*k +: 8];
`ifdef CONTROLLER_REGISTERS_SOCD_FILTER_EN
      // Opposing directions held together read as neither.
      assign btn_f[k] = {raw[7:4],
                         (raw[3] & raw[2]) ? 2'b00 : raw[3:2],
                         (raw[1] & raw[0]) ? 2'b00 : raw[1:0]};
`else
      assign btn_f[k] = raw;
`endif
      assign hit        = cpu_read_en && (rd_idx == 2'(k));
      assign clr_prs[k] = hit && (rd_sel == 2'd1);
      assign clr_rel[k] = hit && (rd_sel == 2'd2);

      controller_registers_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .sample_i  (do_sample),
        .clr_prs_i (clr_prs[k]),
        .clr_rel_i (clr_rel[k]),
        .btn_i     (btn_f[k]),
        .cur_o     (cur[k]),
        .prs_o     (prs[k]),
        .rel_o     (rel[k])
      );
    end
  endgenerate

  // Unpopulated controller slots fall through to 0x00.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      if (rd_idx == 2'(i)) begin
        case (rd_sel)
          2'd0:    rd_data = cur[i];
          2'd1:    rd_data = prs[i];
          2'd2:    rd_data = rel[i];
          default: rd_data = frame_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 8'h00;
      dout_q  <= 8'h00;
      sv_q    <= 1'b0;
    end else begin
      sv_q <= do_sample;
      if (do_sample)   frame_q <= frame_q + 8'h01;
      if (cpu_read_en) dout_q  <= rd_data;
    end
  end

  assign cpu_data_out = dout_q;
  assign sample_valid = sv_q;
endmodule

// File: tb/tb_controller_registers.sv
// Randomized bench for controller_registers against a time-based reference model.
// Honours CONTROLLER_REGISTERS_SOCD_FILTER_EN in the model when the macro is defined.

module tb_controller_registers;
  localparam int NC = 2;
  localparam int S  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vblank_start = 1'b0;
  logic          start_fetch;
  logic [8*NC-1:0] btns = '0;
  logic [3:0]    addr = 4'h0;
  logic          rd_en = 1'b0;
  logic [7:0]    cpu_data_out;
  logic          sample_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap_at = -100;
  int sf_cnt = 0;
  int sv_cnt = 0;

  logic [7:0] m_cur[NC], m_prs[NC], m_rel[NC];
  logic [7:0] m_frame, m_dout;
  logic       exp_sf, exp_sv;

  always #5 clk = ~clk;

  controller_registers #(.NUM_CONTROLLERS(NC), .SETTLE_CYCLES(S)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .vblank_start               (vblank_start),
    .start_fetch                (start_fetch),
    .controller_buttons_in_LIST (btns),
    .cpu_address                (addr),
    .cpu_read_en                (rd_en),
    .cpu_data_out               (cpu_data_out),
    .sample_valid               (sample_valid)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] socd(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef CONTROLLER_REGISTERS_SOCD_FILTER_EN
    if (b[3] && b[2]) r[3:2] = 2'b00;
    if (b[1] && b[0]) r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  // Capture happens SETTLE+2 edges after an accepted vblank; the block is busy until then.
  task automatic model();
    int idx;
    logic [7:0] val, f;
    if (rst) begin
      for (int k = 0; k < NC; k++) begin
        m_cur[k] = 8'h00; m_prs[k] = 8'h00; m_rel[k] = 8'h00;
      end
      m_frame = 8'h00; m_dout = 8'h00; cap_at = -100;
      exp_sf = 1'b0; exp_sv = 1'b0;
    end else begin
      exp_sf = 1'b0; exp_sv = 1'b0;
      if (rd_en) begin
        idx = int'(addr[3:2]);
        val = 8'h00;
        if (idx < NC) begin
          case (addr[1:0])
            2'd0: val = m_cur[idx];
            2'd1: begin val = m_prs[idx]; m_prs[idx] = 8'h00; end
            2'd2: begin val = m_rel[idx]; m_rel[idx] = 8'h00; end
            default: val = m_frame;
          endcase
        end
        m_dout = val;
      end
      if (cyc == cap_at) begin
        for (int k = 0; k < NC; k++) begin
          f = socd(btns[8*k +: 8]);
          m_prs[k] = m_prs[k] | (f & ~m_cur[k]);
          m_rel[k] = m_rel[k] | (~f & m_cur[k]);
          m_cur[k] = f;
        end
        m_frame = m_frame + 8'h01;
        exp_sv = 1'b1;
      end
      if (vblank_start && cyc > cap_at) begin
        cap_at = cyc + 2 + S;
        exp_sf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic rv, input logic [3:0] a);
    rst = r; vblank_start = v; rd_en = rv; addr = a;
    @(posedge clk);
    cyc++;
    model();
    #1;
    chk("start_fetch", {7'b0, start_fetch}, {7'b0, exp_sf});
    chk("sample_valid", {7'b0, sample_valid}, {7'b0, exp_sv});
    chk("cpu_data_out", cpu_data_out, m_dout);
    if (start_fetch)  sf_cnt++;
    if (sample_valid) sv_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic frame();
    step(1'b0, 1'b1, 1'b0, 4'h0);
    idle(S + 3);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    do_reset();
    chk("rst_dout", cpu_data_out, 8'h00);

    // Reset during settle: no sample, everything reads zero, next vblank still works.
    btns = 16'h00FF;
    sv_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 4'h0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    idle(S + 5);
    chk("rst_mid_no_sv", 8'(sv_cnt), 8'h00);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("rst_mid_read", cpu_data_out, 8'h00);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0);
    chk("rst_mid_refetch", {7'b0, start_fetch}, 8'h01);
    do_reset();

    // Latency
    btns = 16'h0081;
    step(1'b0, 1'b1, 1'b0, 4'h0);
    chk("lat_sf_t1", {7'b0, start_fetch}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    chk("lat_sf_t2", {7'b0, start_fetch}, 8'h00);
    idle(S);
    chk("lat_sv_early", {7'b0, sample_valid}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    chk("lat_sv", {7'b0, sample_valid}, 8'h01);
    idle(1);
    rd(4'h0); chk("lat_reg0", cpu_data_out, 8'h81);
    rd(4'h3); chk("lat_reg3", cpu_data_out, 8'h01);

    // Edge flags
    do_reset();
    btns = 16'h0080; frame();
    btns = 16'h0040; frame();
    rd(4'h1); chk("edge_pressed", cpu_data_out, 8'hC0);
    rd(4'h2); chk("edge_released", cpu_data_out, 8'h80);
    rd(4'h1); chk("edge_pressed_clr", cpu_data_out, 8'h00);

    // Clear-on-read on the capture edge
    do_reset();
    btns = 16'h0001; frame();
    btns = 16'h0010;
    step(1'b0, 1'b1, 1'b0, 4'h0);
    idle(S + 1);
    rd(4'h1); chk("coll_old", cpu_data_out, 8'h01);
    idle(1);
    rd(4'h1); chk("coll_new", cpu_data_out, 8'h10);

    // Out-of-range index, ignored vblank, frame wrap
    rd(4'hC); chk("range_c", cpu_data_out, 8'h00);
    rd(4'hF); chk("range_f", cpu_data_out, 8'h00);
    sf_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 4'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    idle(S + 3);
    chk("one_fetch", 8'(sf_cnt), 8'h01);
    do_reset();
    repeat (256) frame();
    rd(4'h3); chk("wrap_reg3", cpu_data_out, 8'h00);
    rd(4'h7); chk("wrap_reg3_c1", cpu_data_out, 8'h00);

    // SOCD filtering
    do_reset();
    btns = 16'h3F3F; frame();
    rd(4'h0);
`ifdef CONTROLLER_REGISTERS_SOCD_FILTER_EN
    chk("socd_reg0", cpu_data_out, 8'h30);
`else
    chk("socd_reg0", cpu_data_out, 8'h3F);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) btns = 16'($urandom);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
